// File: rtl/grayscale_lightness_if.sv
// Pixel-in / lightness-out bus for the grayscale converter.
// master drives pixels and start; slave (the converter) returns results.
interface grayscale_lightness_if;
    logic        i_grayscale_start;
    logic [31:0] i_RGB;
    logic        o_grayscale_data_ready;
    logic [7:0]  o_gray;

    modport master (
        output i_grayscale_start,
        output i_RGB,
        input  o_grayscale_data_ready,
        input  o_gray
    );

    modport slave (
        input  i_grayscale_start,
        input  i_RGB,
        output o_grayscale_data_ready,
        output o_gray
    );
endinterface

// File: rtl/grayscale_lightness.sv
// Three-stage RGB-to-lightness converter: gray = (max(R,G,B) + min(R,G,B)) >> 1.
// A valid bit travels alongside each pixel; results emerge with a one-cycle ready pulse.
module grayscale_lightness (
    input  logic                   clk,
    input  logic                   n_rst,
    grayscale_lightness_if.slave   bus
);
    localparam int unsigned CH_W  = 8;
    localparam int unsigned SUM_W = CH_W + 1;

    logic [CH_W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic             v1_q, v1_d;
    logic [CH_W-1:0]  mx_q, mx_d, mn_q, mn_d;
    logic             v2_q, v2_d;
    logic [CH_W-1:0]  gray_q, gray_d;
    logic             rdy_q, rdy_d;

    logic [CH_W-1:0]  mx_rg, mn_rg;
    logic [SUM_W-1:0] sum;

    // Low byte of the pixel word carries no colour information.
    logic unused_rgb_lsb;
    assign unused_rgb_lsb = ^bus.i_RGB[7:0];

    always_comb begin
        r_d    = bus.i_RGB[31:24];
        g_d    = bus.i_RGB[23:16];
        b_d    = bus.i_RGB[15:8];
        v1_d   = bus.i_grayscale_start;

        mx_rg  = (r_q > g_q) ? r_q : g_q;
        mn_rg  = (r_q < g_q) ? r_q : g_q;
        mx_d   = (mx_rg > b_q) ? mx_rg : b_q;
        mn_d   = (mn_rg < b_q) ? mn_rg : b_q;
        v2_d   = v1_q;

        // 9-bit sum then drop the LSB: floor average, cannot overflow.
        sum    = SUM_W'(mx_q) + SUM_W'(mn_q);
        gray_d = v2_q ? sum[SUM_W-1:1] : gray_q;
        rdy_d  = v2_q;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            v1_q   <= 1'b0;
            mx_q   <= '0;
            mn_q   <= '0;
            v2_q   <= 1'b0;
            gray_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            v1_q   <= v1_d;
            mx_q   <= mx_d;
            mn_q   <= mn_d;
            v2_q   <= v2_d;
            gray_q <= gray_d;
            rdy_q  <= rdy_d;
        end
    end

    assign bus.o_gray                 = gray_q;
    assign bus.o_grayscale_data_ready = rdy_q;
endmodule

// File: tb/tb_grayscale_lightness.sv
// Scoreboard bench for grayscale_lightness: directed pixels with hand-computed lightness.
// Driver pushes expected results tagged with their due cycle; monitor checks every cycle.
module tb_grayscale_lightness;
    logic clk;
    logic n_rst;

    grayscale_lightness_if bus ();

    grayscale_lightness dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] gray;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] last_gray = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        logic rst_s;
        logic exp_rdy;
        logic [7:0] exp_gray;
        forever begin
            @(posedge clk);
            rst_s = n_rst;
            #1;
            if (!rst_s) begin
                q.delete();
                last_gray = 8'd0;
                exp_rdy   = 1'b0;
            end else begin
                exp_rdy = (q.size() > 0) && (q[0].due == cyc);
            end
            if (exp_rdy) begin
                exp_gray  = q[0].gray;
                last_gray = exp_gray;
                void'(q.pop_front());
            end else begin
                exp_gray = last_gray;
            end
            total++;
            if (bus.o_grayscale_data_ready !== exp_rdy) begin
                bad++;
                $display("FAIL ready cyc=%0d: got %b want %b", cyc, bus.o_grayscale_data_ready, exp_rdy);
            end
            total++;
            if (bus.o_gray !== exp_gray) begin
                bad++;
                $display("FAIL gray cyc=%0d: got %0d want %0d", cyc, bus.o_gray, exp_gray);
            end
        end
    end

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] gray);
        exp_t e;
        @(negedge clk);
        bus.i_grayscale_start = 1'b1;
        bus.i_RGB             = {r, g, b, 8'hA5};
        if (n_rst) begin
            e.gray = gray;
            e.due  = cyc + 3;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_grayscale_start = 1'b0;
            bus.i_RGB             = {r, g, b, 8'h5A};
        end
    endtask

    initial begin
        n_rst                 = 1'b0;
        bus.i_grayscale_start = 1'b0;
        bus.i_RGB             = {8'd200, 8'd100, 8'd130, 8'h00};

        // Reset state, including a start sampled under reset.
        idle(2, 8'd200, 8'd100, 8'd130);
        send(8'd200, 8'd100, 8'd130, 8'd150);
        idle(1, 8'd200, 8'd100, 8'd130);
        @(negedge clk);
        n_rst = 1'b1;
        idle(4, 8'd200, 8'd100, 8'd130);

        // Isolated pixels.
        send(8'd200, 8'd100, 8'd130, 8'd150); idle(4, 8'd0, 8'd0, 8'd0);
        send(8'd55,  8'd155, 8'd125, 8'd105); idle(4, 8'd0, 8'd0, 8'd0);
        send(8'd124, 8'd122, 8'd122, 8'd123); idle(4, 8'd0, 8'd0, 8'd0);

        // Truncation cases.
        send(8'd11,  8'd101, 8'd254, 8'd132); idle(3, 8'd9, 8'd9, 8'd9);
        send(8'd255, 8'd240, 8'd230, 8'd242); idle(3, 8'd9, 8'd9, 8'd9);
        send(8'd153, 8'd247, 8'd94,  8'd170); idle(2, 8'd9, 8'd9, 8'd9);
        send(8'd153, 8'd94,  8'd247, 8'd170); idle(2, 8'd9, 8'd9, 8'd9);
        send(8'd11,  8'd11,  8'd222, 8'd116); idle(1, 8'd9, 8'd9, 8'd9);
        send(8'd220, 8'd220, 8'd21,  8'd120); idle(4, 8'd9, 8'd9, 8'd9);

        // Extremes.
        send(8'd255, 8'd255, 8'd255, 8'd255); idle(4, 8'd0, 8'd0, 8'd0);
        send(8'd100, 8'd100, 8'd100, 8'd100); idle(4, 8'd0, 8'd0, 8'd0);
        send(8'd100, 8'd99,  8'd101, 8'd100); idle(4, 8'd0, 8'd0, 8'd0);
        send(8'd0,   8'd0,   8'd0,   8'd0);   idle(5, 8'd77, 8'd77, 8'd77);

        // Streaming, then idle inputs must not disturb o_gray.
        send(8'd200, 8'd100, 8'd130, 8'd150);
        send(8'd55,  8'd155, 8'd125, 8'd105);
        send(8'd11,  8'd101, 8'd254, 8'd132);
        send(8'd255, 8'd240, 8'd230, 8'd242);
        send(8'd153, 8'd247, 8'd94,  8'd170);
        send(8'd11,  8'd11,  8'd222, 8'd116);
        send(8'd220, 8'd220, 8'd21,  8'd120);
        send(8'd124, 8'd122, 8'd122, 8'd123);
        idle(6, 8'd255, 8'd255, 8'd255);

        // Reset with pixels in flight; no stale pulses afterwards.
        send(8'd255, 8'd255, 8'd255, 8'd255);
        send(8'd100, 8'd99,  8'd101, 8'd100);
        send(8'd200, 8'd100, 8'd130, 8'd150);
        @(negedge clk);
        n_rst                 = 1'b0;
        bus.i_grayscale_start = 1'b1;
        @(negedge clk);
        n_rst                 = 1'b1;
        bus.i_grayscale_start = 1'b0;
        idle(6, 8'd255, 8'd255, 8'd255);

        // Post-reset sanity.
        send(8'd55, 8'd155, 8'd125, 8'd105);
        idle(8, 8'd0, 8'd0, 8'd0);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
